mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data RAM between three requesters: instruction fetch, data load/store, and the host program loader.
- Sits between the CPU's two memory interfaces, the loader, and the RAM macro.
- Fixed-priority arbitration with a starvation guard for fetch.
- One access in flight at a time; read data is returned with a valid pulse.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// FSM states, access owners, winner bit positions and counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_DATA,
    OWN_FETCH
  } owner_e;

  // Bit positions inside the one-hot winner vector.
  localparam int W_LD    = 0;
  localparam int W_DATA  = 1;
  localparam int W_FETCH = 2;

  // Starvation counter is sized for the largest legal MAX_WAIT.
  localparam int MAX_WAIT_LIM = 15;
  localparam int SCW = $clog2(MAX_WAIT_LIM + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority winner select: ld > data > fetch, or ld > fetch > data
// when starve_i is set. Ports: three requests + starve flag in, one-hot win_o out.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ld_req_i,
  input  logic       data_req_i,
  input  logic       fetch_req_i,
  input  logic       starve_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = '0;
    if (ld_req_i)
      win_o[W_LD] = 1'b1;
    else if (starve_i && fetch_req_i)
      win_o[W_FETCH] = 1'b1;
    else if (data_req_i)
      win_o[W_DATA] = 1'b1;
    else if (fetch_req_i)
      win_o[W_FETCH] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between loader, data and fetch requesters.
// Ports: ld_*/data_*/fetch_* request sides, ram_* macro side, busy_o status.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          ld_gnt_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [DW-1:0] fetch_rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          busy_o
);

  // WAIT lasts RD_LAT-1 cycles; the counter is loaded with that minus one.
  localparam logic [1:0] LAT_INIT =
    (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [1:0]     lat_q, lat_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic           ram_we_q, ram_we_d;
  logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;
  logic [DW-1:0]  f_rdata_q, f_rdata_d;
  logic           d_rvalid_q, d_rvalid_d;
  logic           f_rvalid_q, f_rvalid_d;

  logic       any_req;
  logic       starve;
  logic [2:0] win;

  assign any_req = ld_req_i | data_req_i | fetch_req_i;
  assign starve  = (starve_q == SCW'(MAX_WAIT));

  mem_arb_pick u_pick (
    .ld_req_i    (ld_req_i),
    .data_req_i  (data_req_i),
    .fetch_req_i (fetch_req_i),
    .starve_i    (starve),
    .win_o       (win)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    d_rdata_d   = d_rdata_q;
    f_rdata_d   = f_rdata_q;
    d_rvalid_d  = 1'b0;
    f_rvalid_d  = 1'b0;

    if (!fetch_req_i)
      starve_d = '0;

    unique case (state_q)
      IDLE, RESP: begin
        // RESP is the cycle ram_rdata is valid; rvalid follows next cycle.
        if (state_q == RESP) begin
          if (owner_q == OWN_DATA) begin
            d_rdata_d  = ram_rdata_i;
            d_rvalid_d = 1'b1;
          end else if (owner_q == OWN_FETCH) begin
            f_rdata_d  = ram_rdata_i;
            f_rvalid_d = 1'b1;
          end
        end
        if (any_req) begin
          state_d = ISSUE;
          unique case (1'b1)
            win[W_LD]: begin
              owner_d     = OWN_LD;
              ram_addr_d  = ld_addr_i;
              ram_we_d    = 1'b1;
              ram_wdata_d = ld_wdata_i;
            end
            win[W_DATA]: begin
              owner_d     = OWN_DATA;
              ram_addr_d  = data_addr_i;
              ram_we_d    = data_we_i;
              ram_wdata_d = data_wdata_i;
              if (fetch_req_i && !starve)
                starve_d = starve_q + 1'b1;
            end
            win[W_FETCH]: begin
              owner_d    = OWN_FETCH;
              ram_addr_d = fetch_addr_i;
              ram_we_d   = 1'b0;
              starve_d   = '0;
            end
            default: ;
          endcase
        end else begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      ISSUE: begin
        ram_we_d = 1'b0;
        if (ram_we_q) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end else if (RD_LAT == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0)
          state_d = RESP;
        else
          lat_d = lat_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      lat_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      d_rdata_q   <= '0;
      f_rdata_q   <= '0;
      d_rvalid_q  <= 1'b0;
      f_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      d_rdata_q   <= d_rdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      f_rvalid_q  <= f_rvalid_d;
    end
  end

  assign ld_gnt_o       = (state_q == ISSUE) && (owner_q == OWN_LD);
  assign data_gnt_o     = (state_q == ISSUE) && (owner_q == OWN_DATA);
  assign fetch_gnt_o    = (state_q == ISSUE) && (owner_q == OWN_FETCH);
  assign data_rvalid_o  = d_rvalid_q;
  assign data_rdata_o   = d_rdata_q;
  assign fetch_rvalid_o = f_rvalid_q;
  assign fetch_rdata_o  = f_rdata_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_we_o       = ram_we_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboarded RD_LAT=1 instance plus
// a cycle-checked RD_LAT=3 instance with its own RAM model.
module tb_mem_port_arbiter;

  localparam logic [2:0] G_LD = 3'b001;
  localparam logic [2:0] G_D  = 3'b010;
  localparam logic [2:0] G_F  = 3'b100;
  localparam logic [1:0] R_D  = 2'b01;
  localparam logic [1:0] R_F  = 2'b10;

  typedef struct {
    logic [2:0]  who;
    logic [10:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RD_LAT=1
  logic rst;
  logic ld_req, ld_gnt;
  logic [10:0] ld_addr;
  logic [31:0] ld_wdata;
  logic data_req, data_we, data_gnt, data_rvalid;
  logic [10:0] data_addr;
  logic [31:0] data_wdata, data_rdata;
  logic fetch_req, fetch_gnt, fetch_rvalid;
  logic [10:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic [10:0] ram_addr;
  logic ram_we, busy;
  logic [31:0] ram_wdata, ram_rdata;

  mem_port_arbiter #(.AW(11), .DW(32), .RD_LAT(1), .MAX_WAIT(3)) u_dut (
    .clk(clk), .rst(rst),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid),
    .fetch_rdata_o(fetch_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (rst) begin
      mem[11'h010] <= 32'hE3A01005;
      for (int i = 0; i < 5; i++) mem[11'h100 + i] <= 32'hA0000000 + i;
      for (int i = 0; i < 2; i++) mem[11'h300 + i] <= 32'hF0000000 + i;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // second instance, RD_LAT=3
  logic rst3;
  logic f3_req, f3_gnt, f3_rvalid;
  logic [10:0] f3_addr;
  logic [31:0] f3_rdata;
  logic d3_req, d3_gnt, d3_rvalid;
  logic [10:0] d3_addr;
  logic [31:0] d3_rdata;
  logic ld3_gnt;
  logic [10:0] ram3_addr;
  logic ram3_we, busy3;
  logic [31:0] ram3_wdata, ram3_rdata;
  logic [31:0] p3 [0:2];

  mem_port_arbiter #(.AW(11), .DW(32), .RD_LAT(3), .MAX_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .ld_req_i(1'b0), .ld_addr_i(11'h0), .ld_wdata_i(32'h0),
    .ld_gnt_o(ld3_gnt),
    .data_req_i(d3_req), .data_we_i(1'b0), .data_addr_i(d3_addr),
    .data_wdata_i(32'h0), .data_gnt_o(d3_gnt),
    .data_rvalid_o(d3_rvalid), .data_rdata_o(d3_rdata),
    .fetch_req_i(f3_req), .fetch_addr_i(f3_addr),
    .fetch_gnt_o(f3_gnt), .fetch_rvalid_o(f3_rvalid),
    .fetch_rdata_o(f3_rdata),
    .ram_addr_o(ram3_addr), .ram_we_o(ram3_we), .ram_wdata_o(ram3_wdata),
    .ram_rdata_i(ram3_rdata), .busy_o(busy3)
  );

  logic [31:0] mem3 [0:2047];
  always @(posedge clk) begin
    if (rst3) begin
      mem3[11'h7FF] <= 32'hCAFEF00D;
      mem3[11'h020] <= 32'h55AA0020;
      mem3[11'h021] <= 32'h55AA0021;
    end else if (ram3_we) begin
      mem3[ram3_addr] <= ram3_wdata;
    end
    p3[0] <= mem3[ram3_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram3_rdata = p3[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void pg(input logic [2:0] w, input logic [10:0] a,
                             input logic we, input logic [31:0] d);
    gexp_t e;
    e.who = w; e.addr = a; e.we = we; e.wdata = d;
    gq.push_back(e);
  endfunction

  function automatic void pr(input logic [1:0] w, input logic [31:0] d);
    rexp_t e;
    e.who = w; e.data = d;
    rq.push_back(e);
  endfunction

  // scoreboard monitor for the main instance
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    logic [2:0] gv;
    logic [1:0] rv;
    if (!rst) begin
      gv = {fetch_gnt, data_gnt, ld_gnt};
      if (gv != 3'b000) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 64'(gv), 64'h0);
        end else begin
          g = gq.pop_front();
          chk("gnt_who", 64'(gv), 64'(g.who));
          chk("ram_addr", 64'(ram_addr), 64'(g.addr));
          chk("ram_we", 64'(ram_we), 64'(g.we));
          if (g.we) chk("ram_wdata", 64'(ram_wdata), 64'(g.wdata));
        end
      end
      rv = {fetch_rvalid, data_rvalid};
      if (rv != 2'b00) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 64'(rv), 64'h0);
        end else begin
          r = rq.pop_front();
          chk("rvalid_who", 64'(rv), 64'(r.who));
          chk("rdata", 64'(rv[1] ? fetch_rdata : data_rdata), 64'(r.data));
        end
      end
      if (ram_we) chk("ram_we_pulse", 64'(prev_we), 64'h0);
      prev_we = ram_we;
    end
  end

  function automatic logic gsel(input int w);
    case (w)
      0: return ld_gnt;
      1: return data_gnt;
      default: return fetch_gnt;
    endcase
  endfunction

  task automatic wait_gnt(input int w);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gsel(w) && n < 50);
    if (!gsel(w)) chk("gnt_timeout", 64'h0, 64'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || gq.size() != 0 || rq.size() != 0) && n < 60);
    chk("idle_timeout", 64'(busy), 64'h0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    rst = 1'b1; rst3 = 1'b1;
    ld_req = 0; ld_addr = 0; ld_wdata = 0;
    data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    fetch_req = 0; fetch_addr = 0;
    f3_req = 0; f3_addr = 0; d3_req = 0; d3_addr = 0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gnts", 64'({ld_gnt, data_gnt, fetch_gnt}), 0);
    chk("rst_rvalids", 64'({data_rvalid, fetch_rvalid}), 0);
    chk("rst_ram_we", 64'(ram_we), 0);
    chk("rst_ram_addr", 64'(ram_addr), 0);
    chk("rst_ram_wdata", 64'(ram_wdata), 0);
    chk("rst_rdata", 64'({data_rdata, fetch_rdata}), 0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // fetch only, exact cycle timing
    pg(G_F, 11'h010, 1'b0, 32'h0);
    pr(R_F, 32'hE3A01005);
    @(posedge clk); #1;
    fetch_addr = 11'h010; fetch_req = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t1_gnt_c%0d", k), 64'(fetch_gnt), 64'(k == 1));
      chk($sformatf("t1_rv_c%0d", k), 64'(fetch_rvalid), 64'(k == 3));
      if (k == 1) begin
        chk("t1_ram_addr", 64'(ram_addr), 64'h010);
        fetch_req = 1'b0;
      end
      if (k == 3) chk("t1_rdata", 64'(fetch_rdata), 64'hE3A01005);
    end
    wait_idle();

    // store then load
    pg(G_D, 11'h200, 1'b1, 32'hDEADBEEF);
    data_we = 1'b1; data_addr = 11'h200; data_wdata = 32'hDEADBEEF;
    data_req = 1'b1;
    wait_gnt(1);
    data_req = 1'b0;
    wait_idle();
    pg(G_D, 11'h200, 1'b0, 32'h0);
    pr(R_D, 32'hDEADBEEF);
    data_we = 1'b0; data_req = 1'b1;
    wait_gnt(1);
    data_req = 1'b0;
    wait_idle();

    // contention: data,data,data,fetch,data,data,fetch
    for (int i = 0; i < 3; i++) pg(G_D, 11'h100 + 11'(i), 1'b0, 32'h0);
    pg(G_F, 11'h300, 1'b0, 32'h0);
    for (int i = 3; i < 5; i++) pg(G_D, 11'h100 + 11'(i), 1'b0, 32'h0);
    pg(G_F, 11'h301, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) pr(R_D, 32'hA0000000 + i);
    pr(R_F, 32'hF0000000);
    for (int i = 3; i < 5; i++) pr(R_D, 32'hA0000000 + i);
    pr(R_F, 32'hF0000001);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          data_we = 1'b0; data_addr = 11'h100 + 11'(i); data_req = 1'b1;
          wait_gnt(1);
        end
        data_req = 1'b0;
      end
      begin
        for (int i = 0; i < 2; i++) begin
          fetch_addr = 11'h300 + 11'(i); fetch_req = 1'b1;
          wait_gnt(2);
        end
        fetch_req = 1'b0;
      end
    join
    wait_idle();

    // loader first, then data, then fetch
    pg(G_LD, 11'h050, 1'b1, 32'h12345678);
    pg(G_D, 11'h101, 1'b0, 32'h0);
    pg(G_F, 11'h301, 1'b0, 32'h0);
    pr(R_D, 32'hA0000001);
    pr(R_F, 32'hF0000001);
    fork
      begin
        ld_addr = 11'h050; ld_wdata = 32'h12345678; ld_req = 1'b1;
        wait_gnt(0);
        ld_req = 1'b0;
      end
      begin
        data_we = 1'b0; data_addr = 11'h101; data_req = 1'b1;
        wait_gnt(1);
        data_req = 1'b0;
      end
      begin
        fetch_addr = 11'h301; fetch_req = 1'b1;
        wait_gnt(2);
        fetch_req = 1'b0;
      end
    join
    wait_idle();
    pg(G_F, 11'h050, 1'b0, 32'h0);
    pr(R_F, 32'h12345678);
    fetch_addr = 11'h050; fetch_req = 1'b1;
    wait_gnt(2);
    fetch_req = 1'b0;
    wait_idle();

    // RD_LAT=3 fetch of 0x7FF
    @(posedge clk); #1;
    f3_addr = 11'h7FF; f3_req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt_c%0d", k), 64'(f3_gnt), 64'(k == 1));
      chk($sformatf("t5_busy_c%0d", k), 64'(busy3), 64'(k >= 1 && k <= 4));
      chk($sformatf("t5_rv_c%0d", k), 64'(f3_rvalid), 64'(k == 5));
      if (k == 1) f3_req = 1'b0;
      if (k == 5) chk("t5_rdata", 64'(f3_rdata), 64'hCAFEF00D);
    end

    // RD_LAT=3 data load, then a load cut by reset in WAIT
    @(posedge clk); #1;
    d3_addr = 11'h021; d3_req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) d3_req = 1'b0;
      if (k == 5) begin
        chk("t6_rv_pre", 64'(d3_rvalid), 64'h1);
        chk("t6_rdata_pre", 64'(d3_rdata), 64'h55AA0021);
      end
    end
    @(posedge clk); #1;
    d3_addr = 11'h020; d3_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_gnt", 64'(d3_gnt), 64'h1);
    d3_req = 1'b0;
    @(negedge clk);
    chk("t6_in_wait", 64'(busy3), 64'h1);
    rst3 = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy3), 0);
    chk("t6_rst_gnt", 64'({ld3_gnt, d3_gnt, f3_gnt}), 0);
    chk("t6_rst_rv", 64'({d3_rvalid, f3_rvalid}), 0);
    chk("t6_rst_ram", 64'({ram3_we, ram3_addr}), 0);
    chk("t6_rst_wdata", 64'(ram3_wdata), 0);
    chk("t6_rst_rdata", 64'(d3_rdata), 0);
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    err = 0;
    repeat (8) begin
      @(negedge clk);
      if (d3_rvalid || f3_rvalid) err++;
    end
    chk("t6_no_rv_after_rst", 64'(err), 0);
    @(posedge clk); #1;
    d3_addr = 11'h020; d3_req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t6_rv_c%0d", k), 64'(d3_rvalid), 64'(k == 5));
      if (k == 1) d3_req = 1'b0;
      if (k == 5) chk("t6_rdata_post", 64'(d3_rdata), 64'h55AA0020);
    end

    chk("sb_gq_empty", 64'(gq.size()), 0);
    chk("sb_rq_empty", 64'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
